// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter (open-drain clk/data).
// Optional retry on failure: define PS2_TX_RETRY_EN.
module ps2_host_tx #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int INHIBIT_US  = 100,
  parameter int TIMEOUT_US  = 20_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int INH   = CLK_FREQ_HZ / 1_000_000 * INHIBIT_US;
  localparam int TMO   = CLK_FREQ_HZ / 1_000_000 * TIMEOUT_US;
  localparam int INH_W = (INH > 1) ? $clog2(INH) : 1;
  localparam int TMO_W = (TMO > 1) ? $clog2(TMO) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIB,
    S_SHIFT,
    S_ACK,
    S_WAITI,
    S_DONE,
    S_FAIL
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic                   r_clk_prev;
  logic [7:0]             r_byte;
  logic [9:0]             r_shift;
  logic [3:0]             r_cnt;
  logic [INH_W-1:0]       r_inh;
  logic [TMO_W-1:0]       r_tmo;
  logic                   r_data_oe;
`ifdef PS2_TX_RETRY_EN
  logic [1:0]             r_retry;
`endif

  logic w_clk_s;
  logic w_data_s;
  logic w_fall;
  logic w_inh_end;
  logic w_tmo_hit;

  assign w_clk_s    = r_clk_sync[SYNC_STAGES-1];
  assign w_data_s   = r_data_sync[SYNC_STAGES-1];
  assign w_fall     = r_clk_prev & ~w_clk_s;
  assign w_inh_end  = (r_inh == INH_W'(INH - 1));
  assign w_tmo_hit  = (r_tmo == TMO_W'(TMO - 1));
  assign ps2_data_oe = r_data_oe;

  // Idle bus level is high, so the synchronizers reset to 1 to avoid a false fall.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
      r_clk_prev  <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk_in};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], ps2_data_in};
      r_clk_prev  <= w_clk_s;
    end
  end

  always_comb begin
    w_next     = r_state;
    tx_busy    = 1'b0;
    tx_done    = 1'b0;
    tx_error   = 1'b0;
    ps2_clk_oe = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (tx_start) w_next = S_INHIB;
      end
      S_INHIB: begin
        tx_busy    = 1'b1;
        ps2_clk_oe = 1'b1;
        if (w_inh_end) w_next = S_SHIFT;
      end
      S_SHIFT: begin
        tx_busy = 1'b1;
        if (w_tmo_hit) w_next = S_FAIL;
        else if (w_fall && r_cnt == 4'd9) w_next = S_ACK;
      end
      S_ACK: begin
        tx_busy = 1'b1;
        if (w_tmo_hit) w_next = S_FAIL;
        else if (w_fall) w_next = w_data_s ? S_FAIL : S_WAITI;
      end
      S_WAITI: begin
        tx_busy = 1'b1;
        if (w_tmo_hit) w_next = S_FAIL;
        else if (w_clk_s && w_data_s) w_next = S_DONE;
      end
      S_DONE: begin
        tx_done = 1'b1;
        w_next  = S_IDLE;
      end
      S_FAIL: begin
`ifdef PS2_TX_RETRY_EN
        if (r_retry != 2'd2) begin
          tx_busy = 1'b1;
          w_next  = S_INHIB;
        end else begin
          tx_error = 1'b1;
          w_next   = S_IDLE;
        end
`else
        tx_error = 1'b1;
        w_next   = S_IDLE;
`endif
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_byte    <= 8'h00;
      r_shift   <= '0;
      r_cnt     <= 4'd0;
      r_inh     <= '0;
      r_tmo     <= '0;
      r_data_oe <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      r_retry   <= 2'd0;
`endif
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (tx_start) begin
            r_byte <= tx_data;
            r_inh  <= '0;
`ifdef PS2_TX_RETRY_EN
            r_retry <= 2'd0;
`endif
          end
        end
        S_INHIB: begin
          r_inh <= r_inh + 1'b1;
          // Start bit goes out as the clock is released (request-to-send).
          if (w_inh_end) begin
            r_data_oe <= 1'b1;
            r_shift   <= {1'b1, ~^r_byte, r_byte};
            r_cnt     <= 4'd0;
            r_tmo     <= '0;
          end
        end
        S_SHIFT, S_ACK, S_WAITI: begin
          r_tmo <= r_tmo + 1'b1;
          if (r_state == S_SHIFT && w_fall) begin
            r_data_oe <= ~r_shift[0];
            r_shift   <= {1'b0, r_shift[9:1]};
            r_cnt     <= r_cnt + 1'b1;
          end
        end
        S_FAIL: begin
          r_inh <= '0;
`ifdef PS2_TX_RETRY_EN
          r_retry <= r_retry + 1'b1;
`endif
        end
        default: ;
      endcase
      // Leaving the frame for any reason releases the data line immediately.
      if (w_next == S_FAIL || w_next == S_IDLE) r_data_oe <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - scoreboard bench for ps2_host_tx with a PS/2 device model.
module tb_ps2_host_tx;

  localparam int INH_CYC = 100;
  localparam int TMO_CYC = 2000;
`ifdef PS2_TX_RETRY_EN
  localparam int ATTEMPTS = 3;
`else
  localparam int ATTEMPTS = 1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       tx_busy, tx_done, tx_error;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       bfm_clk = 1'b1;
  logic       bfm_data = 1'b1;
  wire        ps2_clk_in  = bfm_clk & ~ps2_clk_oe;
  wire        ps2_data_in = bfm_data & ~ps2_data_oe;

  ps2_host_tx #(
    .CLK_FREQ_HZ(1_000_000),
    .INHIBIT_US (100),
    .TIMEOUT_US (2000),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk = ~clk;

  int         cyc = 0;
  int         n_vec = 0;
  int         n_miss = 0;
  int         n_done = 0;
  int         n_err = 0;
  int         busy_gaps = 0;
  int         last_inh = 0;
  bit         in_frame = 1'b0;
  logic [9:0] sb_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (tx_done) n_done++;
      if (tx_error) n_err++;
      if (in_frame && !tx_busy && !tx_done && !tx_error) busy_gaps++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stop bit, odd parity, data: what the device should decode.
  function automatic logic [9:0] frame_of(input logic [7:0] b);
    logic par;
    par = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
    return {1'b1, par, b};
  endfunction

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input int pushes);
    @(negedge clk);
    tx_data  = b;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    tx_data  = 8'h00;
    chk("busy_latency", tx_busy, 1);
    chk("clkoe_latency", ps2_clk_oe, 1);
    in_frame = 1'b1;
    for (int i = 0; i < pushes; i++) sb_q.push_back(frame_of(b));
  endtask

  task automatic wait_rts(output int inh, output bit ok);
    ok  = 1'b0;
    inh = 0;
    for (int i = 0; i < 3000; i++) begin
      if (ps2_clk_oe) inh++;
      if (ps2_clk_in && !ps2_data_in && !ps2_clk_oe) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // mode 0: normal ACK, 1: data left high at fall 11, 2: reset after fall 5.
  task automatic dev_frame(input int mode, output logic [9:0] got, output bit ok);
    int inh;
    bit rts;
    got = '0;
    ok  = 1'b0;
    wait_rts(inh, rts);
    if (!rts) begin
      chk("rts_seen", 0, 1);
      return;
    end
    last_inh = inh;
    ticks(10);
    for (int k = 1; k <= 11; k++) begin
      bfm_clk = 1'b0;
      ticks(10);
      if (mode == 2 && k == 5) begin
        reset = 1'b1;
        ticks(1);
        chk("rst_clk_oe", ps2_clk_oe, 0);
        chk("rst_data_oe", ps2_data_oe, 0);
        chk("rst_busy", tx_busy, 0);
        reset    = 1'b0;
        bfm_clk  = 1'b1;
        bfm_data = 1'b1;
        in_frame = 1'b0;
        return;
      end
      ticks(10);
      bfm_clk = 1'b1;
      ticks(10);
      if (k <= 10) got[k-1] = ps2_data_in;
      if (k == 10 && mode != 1) bfm_data = 1'b0;
      ticks(10);
    end
    bfm_data = 1'b1;
    ok = 1'b1;
  endtask

  task automatic check_frame(input string tag, input logic [9:0] got);
    logic [9:0] exp;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
      return;
    end
    exp = sb_q.pop_front();
    chk(tag, got, exp);
  endtask

  task automatic good_tx(input logic [7:0] b, input logic exp_par, input bit inject);
    logic [9:0] got;
    bit         ok;
    bit         seen;
    int         d0, e0, g0, stray;
    d0 = n_done;
    e0 = n_err;
    g0 = busy_gaps;
    send(b, 1);
    if (inject) begin
      fork
        dev_frame(0, got, ok);
        begin
          ticks(150);
          tx_data  = 8'h55;
          tx_start = 1'b1;
          ticks(1);
          tx_start = 1'b0;
          tx_data  = 8'h00;
        end
      join
    end else begin
      dev_frame(0, got, ok);
    end
    if (ok) begin
      check_frame($sformatf("frame_%02h", b), got);
      chk($sformatf("parity_%02h", b), got[8], exp_par);
    end
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (tx_done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    in_frame = 1'b0;
    chk("done_seen", seen, 1);
    ticks(5);
    chk("done_pulses", n_done - d0, 1);
    chk("done_no_err", n_err - e0, 0);
    chk("busy_held", busy_gaps - g0, 0);
    chk("inhibit_cycles", last_inh, INH_CYC);
    if (inject) begin
      stray = 0;
      for (int i = 0; i < 300; i++) begin
        if (ps2_clk_oe || tx_busy) stray++;
        @(negedge clk);
      end
      chk("ignored_start", stray, 0);
      chk("sb_drained", sb_q.size(), 0);
    end
  endtask

  initial begin
    logic [9:0] got;
    bit         ok;
    bit         seen;
    int         inh, d0, e0, t0, t1;

    reset = 1'b1;
    ticks(3);
    chk("rst_busy0", tx_busy, 0);
    chk("rst_done0", tx_done, 0);
    chk("rst_err0", tx_error, 0);
    chk("rst_clkoe0", ps2_clk_oe, 0);
    chk("rst_dataoe0", ps2_data_oe, 0);
    reset = 1'b0;
    ticks(5);

    good_tx(8'hED, 1'b1, 1'b0);
    good_tx(8'h07, 1'b0, 1'b1);
    good_tx(8'hFF, 1'b1, 1'b0);

    // Device never clocks after request-to-send.
    d0 = n_done;
    e0 = n_err;
    send(8'hA5, 0);
    wait_rts(inh, ok);
    chk("tmo_rts", ok, 1);
    t0 = cyc;
    seen = 1'b0;
    for (int i = 0; i < 8000; i++) begin
      if (tx_error) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    t1 = cyc;
    chk("tmo_err_seen", seen, 1);
    chk("tmo_cycles", t1 - t0, (ATTEMPTS - 1) * (TMO_CYC + 1 + INH_CYC) + TMO_CYC);
    chk("tmo_clk_oe", ps2_clk_oe, 0);
    chk("tmo_data_oe", ps2_data_oe, 0);
    in_frame = 1'b0;
    ticks(5);
    chk("tmo_err_pulses", n_err - e0, 1);
    chk("tmo_no_done", n_done - d0, 0);

    // Device leaves data high at fall 11 (no ACK).
    d0 = n_done;
    e0 = n_err;
    send(8'h3C, ATTEMPTS);
    for (int a = 0; a < ATTEMPTS; a++) begin
      dev_frame(1, got, ok);
      if (ok) check_frame("nack_frame", got);
    end
    ticks(50);
    in_frame = 1'b0;
    chk("nack_err_pulses", n_err - e0, 1);
    chk("nack_no_done", n_done - d0, 0);
    chk("nack_data_oe", ps2_data_oe, 0);

    // Reset in the middle of the frame, then a clean send of 0x00.
    d0 = n_done;
    e0 = n_err;
    send(8'h11, 0);
    dev_frame(2, got, ok);
    ticks(50);
    chk("rst_no_done", n_done - d0, 0);
    chk("rst_no_err", n_err - e0, 0);
    good_tx(8'h00, 1'b1, 1'b0);

    chk("sb_final", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
